// File: rtl/fp_div_if.sv
// Handshake and result bundle for the iterative single-precision divider.
interface fp_div_if #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23
);
   localparam int FLP_W = 1 + EXP_W + MANT_W;

   logic              start;
   logic [FLP_W-1:0]  flp_a;
   logic [FLP_W-1:0]  flp_b;
   logic              busy;
   logic              done;
   logic              sign;
   logic [EXP_W-1:0]  exponent;
   logic [MANT_W-1:0] quot;
   logic [EXP_W+1:0]  exp_raw;
   logic              div_zero;

   modport master (
      output start, flp_a, flp_b,
      input  busy, done, sign, exponent, quot, exp_raw, div_zero
   );

   modport slave (
      input  start, flp_a, flp_b,
      output busy, done, sign, exponent, quot, exp_raw, div_zero
   );
endinterface

// File: rtl/fp_div.sv
// Iterative IEEE-754 single-precision divider: restoring mantissa division,
// one quotient bit per clock, truncated result, zero-magnitude flags only.
module fp_div #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23,
   parameter int BIAS   = 127
) (
   input  logic     clk,
   input  logic     rst,
   fp_div_if.slave  bus
);
   localparam int NB = MANT_W + 2;
   localparam int FW = MANT_W + 1;
   localparam int XW = EXP_W + 2;
   localparam int SB = EXP_W + MANT_W;
   localparam int CW = $clog2(NB + 1);

   localparam logic [1:0]    S_IDLE  = 2'd0;
   localparam logic [1:0]    S_DIV   = 2'd1;
   localparam logic [1:0]    S_NORM  = 2'd2;
   localparam logic [CW-1:0] LAST    = CW'(NB - 1);
   localparam logic [XW-1:0] BIAS_X  = XW'(BIAS);
   localparam logic [XW-1:0] EMAX_X  = XW'((1 << EXP_W) - 1);

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NB-1:0]     rem_q, rem_d;
   logic [NB-1:0]     q_q, q_d;
   logic [FW-1:0]     mb_q, mb_d;
   logic [XW-1:0]     e_q, e_d;
   logic              sgn_q, sgn_d;
   logic              dz_q, dz_d;
   logic              zr_q, zr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              sign_q, sign_d;
   logic [EXP_W-1:0]  exponent_q, exponent_d;
   logic [MANT_W-1:0] quot_q, quot_d;
   logic [XW-1:0]     exp_raw_q, exp_raw_d;
   logic              div_zero_q, div_zero_d;

   logic [FW-1:0]     ma_s, mb_s;
   logic              a_zero_s, b_zero_s;
   logic              ge_s;
   logic [NB-1:0]     rem_sub_s;
   logic [XW-1:0]     norm_exp_s;

   assign ma_s       = {1'b1, bus.flp_a[MANT_W-1:0]};
   assign mb_s       = {1'b1, bus.flp_b[MANT_W-1:0]};
   assign a_zero_s   = (bus.flp_a[SB-1:0] == '0);
   assign b_zero_s   = (bus.flp_b[SB-1:0] == '0);
   assign ge_s       = (rem_q >= {1'b0, mb_q});
   assign rem_sub_s  = ge_s ? (rem_q - {1'b0, mb_q}) : rem_q;
   // q[NB-1] is the integer bit; without it the ratio was below one.
   assign norm_exp_s = q_q[NB-1] ? (e_q + BIAS_X) : (e_q + BIAS_X - XW'(1));

   // Next-state and datapath control for IDLE / DIVIDE / NORM.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      q_d        = q_q;
      mb_d       = mb_q;
      e_d        = e_q;
      sgn_d      = sgn_q;
      dz_d       = dz_q;
      zr_d       = zr_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      sign_d     = sign_q;
      exponent_d = exponent_q;
      quot_d     = quot_q;
      exp_raw_d  = exp_raw_q;
      div_zero_d = div_zero_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               mb_d   = mb_s;
               sgn_d  = bus.flp_a[SB] ^ bus.flp_b[SB];
               e_d    = {2'b00, bus.flp_a[SB-1:MANT_W]} - {2'b00, bus.flp_b[SB-1:MANT_W]};
               busy_d = 1'b1;
               cnt_d  = '0;
               q_d    = '0;
               rem_d  = {1'b0, ma_s};
               dz_d   = b_zero_s;
               zr_d   = !b_zero_s && a_zero_s;
               if (b_zero_s || a_zero_s) begin
                  state_d = S_NORM;
               end else begin
                  state_d = S_DIV;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DIV: begin
            q_d   = {q_q[NB-2:0], ge_s};
            rem_d = rem_sub_s << 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = S_NORM;
            end else begin
               state_d = S_DIV;
            end
         end
         S_NORM: begin
            sign_d = sgn_q;
            if (dz_q) begin
               exponent_d = '1;
               quot_d     = '0;
               exp_raw_d  = EMAX_X;
               div_zero_d = 1'b1;
            end else if (zr_q) begin
               exponent_d = '0;
               quot_d     = '0;
               exp_raw_d  = '0;
               div_zero_d = 1'b0;
            end else if (q_q[NB-1]) begin
               exponent_d = norm_exp_s[EXP_W-1:0];
               quot_d     = q_q[NB-2:1];
               exp_raw_d  = norm_exp_s;
               div_zero_d = 1'b0;
            end else begin
               exponent_d = norm_exp_s[EXP_W-1:0];
               quot_d     = q_q[NB-3:0];
               exp_raw_d  = norm_exp_s;
               div_zero_d = 1'b0;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and result registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         q_q        <= '0;
         mb_q       <= '0;
         e_q        <= '0;
         sgn_q      <= 1'b0;
         dz_q       <= 1'b0;
         zr_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sign_q     <= 1'b0;
         exponent_q <= '0;
         quot_q     <= '0;
         exp_raw_q  <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         q_q        <= q_d;
         mb_q       <= mb_d;
         e_q        <= e_d;
         sgn_q      <= sgn_d;
         dz_q       <= dz_d;
         zr_q       <= zr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         sign_q     <= sign_d;
         exponent_q <= exponent_d;
         quot_q     <= quot_d;
         exp_raw_q  <= exp_raw_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.sign     = sign_q;
   assign bus.exponent = exponent_q;
   assign bus.quot     = quot_q;
   assign bus.exp_raw  = exp_raw_q;
   assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed vector table, hand-written corner
// sequences, and random operands against an integer-arithmetic reference.
module tb_fp_div;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fp_div_if #(.EXP_W(8), .MANT_W(23)) bus();

   fp_div #(.EXP_W(8), .MANT_W(23), .BIAS(127)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        sign;
      logic [7:0]  exponent;
      logic [22:0] quot;
      logic [9:0]  exp_raw;
      logic        dz;
   } res_t;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      res_t        exp;
      int          lat;
   } vec_t;

   int total    = 0;
   int passed   = 0;
   int done_cnt = 0;

   always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

   task automatic chk(input string name, input longint got, input longint want);
      total++;
      if (got == want) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
   endtask

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
      res_t        r;
      longint      ma, mb, qv;
      int          e;
      r.sign = a[31] ^ b[31];
      if (b[30:0] == 31'd0) begin
         r.exponent = 8'hFF; r.quot = 23'd0; r.exp_raw = 10'd255; r.dz = 1'b1;
      end else if (a[30:0] == 31'd0) begin
         r.exponent = 8'd0; r.quot = 23'd0; r.exp_raw = 10'd0; r.dz = 1'b0;
      end else begin
         ma = longint'({1'b1, a[22:0]});
         mb = longint'({1'b1, b[22:0]});
         qv = (ma * 64'd16777216) / mb;
         e  = int'(a[30:23]) - int'(b[30:23]);
         if (qv >= 64'd16777216) begin
            qv = qv / 2;
            e  = e + 127;
         end else begin
            e  = e + 126;
         end
         r.quot     = 23'(qv % 64'd8388608);
         r.exp_raw  = 10'(e);
         r.exponent = 8'(e);
         r.dz       = 1'b0;
      end
      return r;
   endfunction

   function automatic logic [42:0] pack(input res_t r);
      return {r.sign, r.exponent, r.quot, r.exp_raw, r.dz};
   endfunction

   function automatic res_t sample();
      res_t r;
      r.sign = bus.sign; r.exponent = bus.exponent; r.quot = bus.quot;
      r.exp_raw = bus.exp_raw; r.dz = bus.div_zero;
      return r;
   endfunction

   // Issue one operation and wait (bounded) for done; lat counts clocks after accept.
   task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        output res_t r, output int lat);
      @(negedge clk);
      bus.flp_a = a; bus.flp_b = b; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.flp_a = $urandom; bus.flp_b = $urandom;
      chk({name, "_busy_set"}, longint'(bus.busy), 64'd1);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      r = sample();
      chk({name, "_busy_clr"}, longint'(bus.busy), 64'd0);
      @(negedge clk);
      chk({name, "_done_pulse"}, longint'(bus.done), 64'd0);
   endtask

   vec_t vecs[$];
   res_t r, prev;
   int   lat, dc;

   function automatic res_t mk(input logic s, input logic [7:0] ex, input logic [22:0] q,
                               input logic [9:0] er, input logic dz);
      res_t x;
      x.sign = s; x.exponent = ex; x.quot = q; x.exp_raw = er; x.dz = dz;
      return x;
   endfunction

   initial begin
      bus.start = 1'b0; bus.flp_a = 32'd0; bus.flp_b = 32'd0;
      vecs.push_back('{"6div2",    32'h40C00000, 32'h40000000, mk(1'b0, 8'h80, 23'h400000, 10'd128, 1'b0), 26});
      vecs.push_back('{"1div3",    32'h3F800000, 32'h40400000, mk(1'b0, 8'h7D, 23'h2AAAAA, 10'd125, 1'b0), 26});
      vecs.push_back('{"m7p5",     32'hC0F00000, 32'h40200000, mk(1'b1, 8'h80, 23'h400000, 10'd128, 1'b0), 26});
      vecs.push_back('{"1div0",    32'h3F800000, 32'h00000000, mk(1'b0, 8'hFF, 23'h000000, 10'd255, 1'b1), 1});
      vecs.push_back('{"0div5",    32'h00000000, 32'h40A00000, mk(1'b0, 8'h00, 23'h000000, 10'd0,   1'b0), 1});
      vecs.push_back('{"ovf",      32'h7F000000, 32'h00800000, mk(1'b0, 8'h7C, 23'h000000, 10'd380, 1'b0), 26});
      vecs.push_back('{"m0div0",   32'h80000000, 32'h00000000, mk(1'b1, 8'hFF, 23'h000000, 10'd255, 1'b1), 1});
      vecs.push_back('{"m0divm5",  32'h80000000, 32'hC0A00000, mk(1'b0, 8'h00, 23'h000000, 10'd0,   1'b0), 1});

      // Reset state.
      repeat (2) @(negedge clk);
      chk("reset_outputs", longint'({bus.busy, bus.done, pack(sample())}), 64'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         do_op(vecs[i].name, vecs[i].a, vecs[i].b, r, lat);
         chk({vecs[i].name, "_result"}, longint'(pack(r)), longint'(pack(vecs[i].exp)));
         chk({vecs[i].name, "_latency"}, longint'(lat), longint'(vecs[i].lat));
      end

      // Hold during a later divide, and a start while busy is ignored.
      do_op("hold_pre", 32'h3F800000, 32'h40400000, prev, lat);
      dc = done_cnt;
      @(negedge clk);
      bus.flp_a = 32'hC0F00000; bus.flp_b = 32'h40200000; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("hold_mid_divide", longint'(pack(sample())), longint'(pack(prev)));
      bus.flp_a = 32'h3F800000; bus.flp_b = 32'h00000000; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 10;
      while (bus.done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("busy_start_latency", longint'(lat), 64'd26);
      chk("busy_start_result", longint'(pack(sample())),
          longint'(pack(mk(1'b1, 8'h80, 23'h400000, 10'd128, 1'b0))));
      repeat (40) @(negedge clk);
      chk("busy_start_one_done", longint'(done_cnt - dc), 64'd1);

      // Reset mid-divide aborts with no done pulse.
      dc = done_cnt;
      bus.flp_a = 32'h40C00000; bus.flp_b = 32'h40000000; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (11) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_outputs", longint'({bus.busy, bus.done, pack(sample())}), 64'd0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("abort_no_done", longint'(done_cnt - dc), 64'd0);
      do_op("restart", 32'h3F800000, 32'h40400000, r, lat);
      chk("restart_result", longint'(pack(r)),
          longint'(pack(mk(1'b0, 8'h7D, 23'h2AAAAA, 10'd125, 1'b0))));
      chk("restart_latency", longint'(lat), 64'd26);

      // Random operands against the reference model.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         res_t        want;
         a = $urandom; b = $urandom;
         if (i % 10 == 3) b[30:0] = 31'd0;
         if (i % 10 == 7) a[30:0] = 31'd0;
         want = model(a, b);
         do_op("rand", a, b, r, lat);
         chk("rand_result", longint'(pack(r)), longint'(pack(want)));
         chk("rand_latency", longint'(lat),
             (b[30:0] == 31'd0 || a[30:0] == 31'd0) ? 64'd1 : 64'd26);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
